// File: rtl/axi_log_pkg.sv
// -----------------------------------------------------------------------------
// axi_log_pkg
// Shared definitions for the AXI address-event capture stage of the BRAM
// logger.
//   log_event_t       packed event layout {is_write, id, addr, len} at the
//                     default widths (ID 8, address 32, length 8)
//   LOG_IS_WRITE_POS  bit position of is_write inside a packed event
//   clog2             ceiling log2, used for pointer and count widths
// -----------------------------------------------------------------------------
package axi_log_pkg;

   typedef struct packed {
      logic        is_write;
      logic [7:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } log_event_t;

   localparam int LOG_IS_WRITE_POS = $bits(log_event_t) - 1;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/log_fifo_2w1r.sv
// -----------------------------------------------------------------------------
// log_fifo_2w1r
// Event FIFO with two write ports and one read port. Port 0 holds the older
// entry when both ports write in the same cycle. The head is removed every
// cycle the FIFO is non-empty, because the consumer never stalls.
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous flush (count and pointers to 0)
//   wr0_en, wr0_data    first (older) write port
//   wr1_en, wr1_data    second write port; only valid together with wr0_en
//   rd_valid, rd_data   registered head of the FIFO, data 0 when empty
//   free                entries that may be written this cycle
// -----------------------------------------------------------------------------
module log_fifo_2w1r
   import axi_log_pkg::*;
#(
   parameter int DATA_BITW = 49,
   parameter int DEPTH     = 4,
   localparam int PTR_BITW = clog2(DEPTH),
   localparam int CNT_BITW = PTR_BITW + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 wr0_en,
   input  logic [DATA_BITW-1:0] wr0_data,
   input  logic                 wr1_en,
   input  logic [DATA_BITW-1:0] wr1_data,
   output logic                 rd_valid,
   output logic [DATA_BITW-1:0] rd_data,
   output logic [CNT_BITW-1:0]  free
);

   logic [DATA_BITW-1:0] mem_q [DEPTH];
   logic [DATA_BITW-1:0] mem_d [DEPTH];
   logic [PTR_BITW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_BITW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_BITW-1:0]  count_q, count_d;
   logic                 rd_valid_q, rd_valid_d;
   logic [DATA_BITW-1:0] rd_data_q, rd_data_d;
   logic                 pop;
   logic                 wr0_go, wr1_go;
   logic [1:0]           n_push;

   assign pop    = (count_q != '0);
   assign wr0_go = wr0_en & ~clear;
   assign wr1_go = wr1_en & wr0_en & ~clear;
   assign n_push = {1'b0, wr0_go} + {1'b0, wr1_go};

   // The slot being popped this cycle is already reusable by a write.
   assign free = CNT_BITW'(DEPTH) - count_q + CNT_BITW'(pop);

   // The head register is loaded with the head of the next-state FIFO so
   // that the read side comes straight from flops and a push into an empty
   // FIFO is visible one cycle later.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q + PTR_BITW'(pop);
      wr_ptr_d = wr_ptr_q + PTR_BITW'(n_push);
      count_d  = count_q + CNT_BITW'(n_push) - CNT_BITW'(pop);
      if (wr0_go) begin
         mem_d[wr_ptr_q] = wr0_data;
      end
      if (wr1_go) begin
         mem_d[wr_ptr_q + PTR_BITW'(1)] = wr1_data;
      end
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
      rd_valid_d = (count_d != '0);
      rd_data_d  = rd_valid_d ? mem_d[rd_ptr_d] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: rtl/axi_log_arbiter.sv
// -----------------------------------------------------------------------------
// axi_log_arbiter
// Capture stage in front of the AXI BRAM logger. Completed AR and AW address
// handshakes become events {is_write, id, addr, len}, are queued in a small
// two-write/one-read FIFO and leave one per cycle on the logger interface.
// Events that find no room are dropped and counted.
//   Clk_CI, Rst_RBI          clock, asynchronous active-low reset
//   Ar*_SI / Ar*_DI          AR channel handshake and payload
//   Aw*_SI / Aw*_DI          AW channel handshake and payload
//   Enable_SI                capture enable
//   Clear_SI                 synchronous flush of FIFO and drop counter
//   LogFull_SI               logger full, inhibits capture
//   LogValid_SO/LogReady_SO  event present (identical signals)
//   LogId_DO                 {is_write, id}
//   LogAddr_DO, LogLen_DO    event address and burst length
//   DropCnt_DO               saturating count of events lost to overflow
// -----------------------------------------------------------------------------
module axi_log_arbiter
   import axi_log_pkg::*;
#(
   parameter int AXI_ADDR_BITW = 32,
   parameter int AXI_ID_BITW   = 8,
   parameter int AXI_LEN_BITW  = 8,
   parameter int FIFO_DEPTH    = 4,
   parameter int DROP_CNT_BITW = 16
) (
   input  logic                     Clk_CI,
   input  logic                     Rst_RBI,
   input  logic                     ArValid_SI,
   input  logic                     ArReady_SI,
   input  logic [AXI_ID_BITW-1:0]   ArId_DI,
   input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
   input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
   input  logic                     AwValid_SI,
   input  logic                     AwReady_SI,
   input  logic [AXI_ID_BITW-1:0]   AwId_DI,
   input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
   input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
   input  logic                     Enable_SI,
   input  logic                     Clear_SI,
   input  logic                     LogFull_SI,
   output logic                     LogValid_SO,
   output logic                     LogReady_SO,
   output logic [AXI_ID_BITW:0]     LogId_DO,
   output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
   output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
   output logic [DROP_CNT_BITW-1:0] DropCnt_DO
);

   // Same layout as log_event_t, generalised to the configured widths; the
   // direction bit is the MSB (LOG_IS_WRITE_POS for the default widths).
   localparam int EVT_BITW  = 1 + AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;
   localparam int CNT_BITW  = clog2(FIFO_DEPTH) + 1;
   localparam int DSUM_BITW = DROP_CNT_BITW + 1;

   logic                     capture_ok;
   logic                     cap_ar, cap_aw;
   logic [EVT_BITW-1:0]      ar_evt, aw_evt;
   logic                     wr0_en, wr1_en;
   logic [EVT_BITW-1:0]      wr0_data, wr1_data;
   logic [1:0]               n_drop;
   logic [CNT_BITW-1:0]      free;
   logic                     head_valid;
   logic [EVT_BITW-1:0]      head_data;
   logic [DSUM_BITW-1:0]     drop_sum;
   logic [DROP_CNT_BITW-1:0] drop_cnt_q, drop_cnt_d;

   // Clear and a full logger both suppress capture entirely; suppressed
   // handshakes are not drops.
   assign capture_ok = Enable_SI & ~LogFull_SI & ~Clear_SI;
   assign cap_ar     = ArValid_SI & ArReady_SI & capture_ok;
   assign cap_aw     = AwValid_SI & AwReady_SI & capture_ok;

   assign ar_evt = {1'b0, ArId_DI, ArAddr_DI, ArLen_DI};
   assign aw_evt = {1'b1, AwId_DI, AwAddr_DI, AwLen_DI};

   // AR is the older event of a same-cycle pair, so it always takes write
   // port 0 and is the one kept when only one slot is free.
   always_comb begin
      wr0_en   = 1'b0;
      wr1_en   = 1'b0;
      wr0_data = ar_evt;
      wr1_data = aw_evt;
      n_drop   = 2'd0;
      if (cap_ar && cap_aw) begin
         if (free >= CNT_BITW'(2)) begin
            wr0_en = 1'b1;
            wr1_en = 1'b1;
         end else if (free == CNT_BITW'(1)) begin
            wr0_en = 1'b1;
            n_drop = 2'd1;
         end else begin
            n_drop = 2'd2;
         end
      end else if (cap_ar || cap_aw) begin
         wr0_data = cap_ar ? ar_evt : aw_evt;
         if (free != '0) begin
            wr0_en = 1'b1;
         end else begin
            n_drop = 2'd1;
         end
      end
   end

   log_fifo_2w1r #(
      .DATA_BITW (EVT_BITW),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk      (Clk_CI),
      .rst_n    (Rst_RBI),
      .clear    (Clear_SI),
      .wr0_en   (wr0_en),
      .wr0_data (wr0_data),
      .wr1_en   (wr1_en),
      .wr1_data (wr1_data),
      .rd_valid (head_valid),
      .rd_data  (head_data),
      .free     (free)
   );

   // One extra bit catches the carry so the counter sticks at all-ones.
   assign drop_sum = {1'b0, drop_cnt_q} + DSUM_BITW'(n_drop);

   always_comb begin
      drop_cnt_d = drop_sum[DROP_CNT_BITW-1:0];
      if (drop_sum[DROP_CNT_BITW]) begin
         drop_cnt_d = '1;
      end
      if (Clear_SI) begin
         drop_cnt_d = '0;
      end
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // The FIFO head register is already zero when empty.
   assign LogValid_SO = head_valid;
   assign LogReady_SO = head_valid;
   assign LogId_DO    = head_data[EVT_BITW-1 -: AXI_ID_BITW+1];
   assign LogAddr_DO  = head_data[AXI_ADDR_BITW+AXI_LEN_BITW-1 : AXI_LEN_BITW];
   assign LogLen_DO   = head_data[AXI_LEN_BITW-1:0];
   assign DropCnt_DO  = drop_cnt_q;

endmodule

// File: tb/tb_axi_log_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_log_arbiter
// Self-checking bench for axi_log_arbiter. A queue-based reference model
// tracks the events the logger should see and the drop count; directed
// scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_axi_log_arbiter;

   localparam int DEPTH     = 4;
   localparam int DROP_BITW = 6;
   localparam int DROP_MAX  = (1 << DROP_BITW) - 1;

   typedef struct packed {
      logic        is_write;
      logic [7:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
   } evt_t;

   typedef struct {
      bit          ar_v;
      bit          ar_r;
      logic [7:0]  ar_id;
      logic [31:0] ar_addr;
      logic [7:0]  ar_len;
      bit          aw_v;
      bit          aw_r;
      logic [7:0]  aw_id;
      logic [31:0] aw_addr;
      logic [7:0]  aw_len;
      bit          en;
      bit          clr;
      bit          full;
   } stim_t;

   logic                 clk;
   logic                 rst_n;
   logic                 ar_valid, ar_ready;
   logic [7:0]           ar_id;
   logic [31:0]          ar_addr;
   logic [7:0]           ar_len;
   logic                 aw_valid, aw_ready;
   logic [7:0]           aw_id;
   logic [31:0]          aw_addr;
   logic [7:0]           aw_len;
   logic                 enable, clear, log_full;
   logic                 log_valid, log_ready;
   logic [8:0]           log_id;
   logic [31:0]          log_addr;
   logic [7:0]           log_len;
   logic [DROP_BITW-1:0] drop_cnt;

   evt_t model_q[$];
   int   model_drop = 0;
   int   test_count = 0;
   int   fail_count = 0;

   axi_log_arbiter #(
      .AXI_ADDR_BITW (32),
      .AXI_ID_BITW   (8),
      .AXI_LEN_BITW  (8),
      .FIFO_DEPTH    (DEPTH),
      .DROP_CNT_BITW (DROP_BITW)
   ) dut (
      .Clk_CI      (clk),
      .Rst_RBI     (rst_n),
      .ArValid_SI  (ar_valid),
      .ArReady_SI  (ar_ready),
      .ArId_DI     (ar_id),
      .ArAddr_DI   (ar_addr),
      .ArLen_DI    (ar_len),
      .AwValid_SI  (aw_valid),
      .AwReady_SI  (aw_ready),
      .AwId_DI     (aw_id),
      .AwAddr_DI   (aw_addr),
      .AwLen_DI    (aw_len),
      .Enable_SI   (enable),
      .Clear_SI    (clear),
      .LogFull_SI  (log_full),
      .LogValid_SO (log_valid),
      .LogReady_SO (log_ready),
      .LogId_DO    (log_id),
      .LogAddr_DO  (log_addr),
      .LogLen_DO   (log_len),
      .DropCnt_DO  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Compare the logger-side outputs against the head of the model queue.
   task automatic checkState();
      logic [50:0] exp_word;
      logic [50:0] obs_word;
      exp_word = '0;
      if (model_q.size() != 0) begin
         exp_word = {1'b1, 1'b1, model_q[0]};
      end
      obs_word = {log_valid, log_ready, log_id, log_addr, log_len};
      checkOutput("event", 64'(obs_word), 64'(exp_word));
      checkOutput("drop_cnt", 64'(drop_cnt), 64'(model_drop));
   endtask

   task automatic modelPush(input evt_t e);
      if (model_q.size() < DEPTH) begin
         model_q.push_back(e);
      end else if (model_drop < DROP_MAX) begin
         model_drop++;
      end
   endtask

   // One clock of the reference: the head leaves, then captures fill the
   // room that remains, AR before AW.
   task automatic modelStep(input stim_t s);
      if (model_q.size() != 0) begin
         void'(model_q.pop_front());
      end
      if (s.clr) begin
         model_q.delete();
         model_drop = 0;
      end else if (s.en && !s.full) begin
         if (s.ar_v && s.ar_r) modelPush({1'b0, s.ar_id, s.ar_addr, s.ar_len});
         if (s.aw_v && s.aw_r) modelPush({1'b1, s.aw_id, s.aw_addr, s.aw_len});
      end
   endtask

   task automatic driveInputs(input stim_t s);
      ar_valid = s.ar_v;
      ar_ready = s.ar_r;
      ar_id    = s.ar_id;
      ar_addr  = s.ar_addr;
      ar_len   = s.ar_len;
      aw_valid = s.aw_v;
      aw_ready = s.aw_r;
      aw_id    = s.aw_id;
      aw_addr  = s.aw_addr;
      aw_len   = s.aw_len;
      enable   = s.en;
      clear    = s.clr;
      log_full = s.full;
   endtask

   // Each call is one clock: outputs are checked at the falling edge, then
   // the new inputs are driven and the model advanced.
   task automatic applyStimulus(input stim_t s);
      @(negedge clk);
      checkState();
      driveInputs(s);
      modelStep(s);
   endtask

   function automatic stim_t idleStim();
      stim_t s;
      s = '{default: 0};
      s.en = 1'b1;
      return s;
   endfunction

   function automatic stim_t arStim(input logic [7:0] id, input logic [31:0] addr,
                                    input logic [7:0] len);
      stim_t s;
      s = idleStim();
      s.ar_v = 1'b1;
      s.ar_r = 1'b1;
      s.ar_id = id;
      s.ar_addr = addr;
      s.ar_len = len;
      return s;
   endfunction

   function automatic stim_t dualStim(input logic [31:0] ar_a, input logic [31:0] aw_a);
      stim_t s;
      s = arStim(8'h21, ar_a, 8'd1);
      s.aw_v = 1'b1;
      s.aw_r = 1'b1;
      s.aw_id = 8'h34;
      s.aw_addr = aw_a;
      s.aw_len = 8'd2;
      return s;
   endfunction

   function automatic stim_t randStim();
      stim_t s;
      s.ar_v    = ($urandom_range(99) < 60);
      s.ar_r    = ($urandom_range(99) < 70);
      s.ar_id   = 8'($urandom);
      s.ar_addr = $urandom;
      s.ar_len  = 8'($urandom);
      s.aw_v    = ($urandom_range(99) < 60);
      s.aw_r    = ($urandom_range(99) < 70);
      s.aw_id   = 8'($urandom);
      s.aw_addr = $urandom;
      s.aw_len  = 8'($urandom);
      s.en      = ($urandom_range(99) < 90);
      s.clr     = ($urandom_range(99) < 3);
      s.full    = ($urandom_range(99) < 10);
      return s;
   endfunction

   initial begin
      stim_t s;

      // Reset values, observed while reset is held.
      rst_n = 1'b0;
      driveInputs(idleStim());
      #3;
      checkOutput("reset_evt", 64'({log_valid, log_ready, log_id, log_addr, log_len}), 64'(0));
      checkOutput("reset_drop", 64'(drop_cnt), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single AR, visible one cycle later for exactly one cycle.
      applyStimulus(arStim(8'h12, 32'h1000_0040, 8'd3));
      applyStimulus(idleStim());
      checkOutput("single_valid", 64'(log_valid), 64'(1));
      checkOutput("single_id", 64'(log_id), 64'(9'h012));
      checkOutput("single_addr", 64'(log_addr), 64'(32'h1000_0040));
      checkOutput("single_len", 64'(log_len), 64'(3));
      applyStimulus(idleStim());
      checkOutput("single_gone", 64'(log_valid), 64'(0));

      // Same-cycle AR+AW: AR first, AW next.
      applyStimulus(dualStim(32'hA0, 32'hB0));
      applyStimulus(idleStim());
      checkOutput("pair_first_dir", 64'(log_id[8]), 64'(0));
      checkOutput("pair_first_addr", 64'(log_addr), 64'(32'hA0));
      applyStimulus(idleStim());
      checkOutput("pair_second_dir", 64'(log_id[8]), 64'(1));
      checkOutput("pair_second_addr", 64'(log_addr), 64'(32'hB0));
      checkOutput("pair_drop", 64'(drop_cnt), 64'(0));
      applyStimulus(idleStim());

      // Six cycles of dual capture: 9 accepted, 3 dropped.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(dualStim(32'h100 + 32'(i * 16), 32'h200 + 32'(i * 16)));
      end
      applyStimulus(idleStim());
      checkOutput("burst_drop", 64'(drop_cnt), 64'(3));
      repeat (5) applyStimulus(idleStim());

      // Sustained overflow drives the counter into saturation.
      for (int i = 0; i < 70; i++) begin
         applyStimulus(dualStim(32'h1000 + 32'(i), 32'h2000 + 32'(i)));
      end
      applyStimulus(idleStim());
      checkOutput("sat_drop", 64'(drop_cnt), 64'(DROP_MAX));

      // Clear with three events queued and a coincident AR.
      applyStimulus(arStim(8'h55, 32'hC0, 8'd7));
      s = arStim(8'h66, 32'hD0, 8'd4);
      s.clr = 1'b1;
      applyStimulus(s);
      checkOutput("clear_head_valid", 64'(log_valid), 64'(1));
      applyStimulus(idleStim());
      checkOutput("clear_valid", 64'(log_valid), 64'(0));
      checkOutput("clear_drop", 64'(drop_cnt), 64'(0));
      applyStimulus(idleStim());
      checkOutput("clear_no_capture", 64'(log_valid), 64'(0));

      // Full logger and disabled capture: queue drains, drops unchanged.
      for (int i = 0; i < 6; i++) begin
         applyStimulus(dualStim(32'h300 + 32'(i), 32'h400 + 32'(i)));
      end
      for (int i = 0; i < 6; i++) begin
         s = dualStim(32'h500 + 32'(i), 32'h600 + 32'(i));
         if (i < 3) s.full = 1'b1;
         else s.en = 1'b0;
         applyStimulus(s);
      end
      applyStimulus(idleStim());
      checkOutput("inhibit_valid", 64'(log_valid), 64'(0));
      checkOutput("inhibit_drop", 64'(drop_cnt), 64'(3));

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(randStim());
      end

      // Asynchronous reset while events are queued.
      applyStimulus(dualStim(32'h7000, 32'h7100));
      applyStimulus(dualStim(32'h7200, 32'h7300));
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_evt", 64'({log_valid, log_ready, log_id, log_addr, log_len}), 64'(0));
      checkOutput("async_rst_drop", 64'(drop_cnt), 64'(0));
      model_q.delete();
      model_drop = 0;
      driveInputs(idleStim());
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 60; i++) begin
         applyStimulus(randStim());
      end
      applyStimulus(idleStim());

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
